// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field positions and exception codes.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Only IM, EXL and IE are implemented in SR.
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Restart address: a delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0: interrupt/exception arbitration at M, EPC/Cause capture, mfc0/mtc0/eret.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2021_0706
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exccode_m,
  input  logic        m_valid,
  input  logic [4:0]  cp0_addr,
  input  logic        cp0_we,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        req,
  output logic [31:0] handler_pc
);

  logic [31:0] r_sr;
  logic [31:0] r_epc;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;

  logic        w_exl, w_ie;
  logic [5:0]  w_im;
  logic        w_int_req, w_exc_req, w_req;
  logic [31:0] w_sr_wr;

  assign w_exl = r_sr[SR_EXL];
  assign w_ie  = r_sr[SR_IE];
  assign w_im  = r_sr[SR_IM_HI:SR_IM_LO];

  // Interrupts look at live lines and SR only; a bubble in M can still be interrupted.
  assign w_int_req = w_ie & ~w_exl & (|(hwint & w_im));
  assign w_exc_req = ~w_exl & m_valid & (exccode_m != EXC_INT);
  assign w_req     = w_int_req | w_exc_req;

  // eret in the same cycle as an SR write still leaves exception level.
  always_comb begin
    w_sr_wr = cp0_wdata & SR_MASK;
    if (eret_m) w_sr_wr[SR_EXL] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr      <= '0;
      r_epc     <= '0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
    end else begin
      r_ip <= hwint;
      if (w_req) begin
        r_sr[SR_EXL] <= 1'b1;
        r_bd         <= bd_m;
        r_exccode    <= w_int_req ? EXC_INT : exccode_m;
        r_epc        <= epc_of(pc_m, bd_m);
      end else begin
        if (cp0_we && cp0_addr == CP0_SR) r_sr <= w_sr_wr;
        else if (eret_m)                  r_sr[SR_EXL] <= 1'b0;
        if (cp0_we && cp0_addr == CP0_EPC) r_epc <= cp0_wdata & 32'hFFFF_FFFC;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR:    cp0_rdata = r_sr;
      CP0_CAUSE: cp0_rdata = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b00};
      CP0_EPC:   cp0_rdata = r_epc;
      CP0_PRID:  cp0_rdata = PRID_VAL;
      default:   cp0_rdata = '0;
    endcase
  end

  assign epc_out    = r_epc;
  assign req        = w_req;
  assign handler_pc = w_req ? HANDLER_PC : 32'h0;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed plus randomized check of cp0_exc_unit against a word-level CP0 model.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hwint;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exccode_m;
  logic        m_valid;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic        eret_m;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        req;
  logic [31:0] handler_pc;

  int total = 0;
  int bad   = 0;

  // Model state as architectural words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_unit dut (
    .clk(clk), .reset(reset), .hwint(hwint), .pc_m(pc_m), .bd_m(bd_m),
    .exccode_m(exccode_m), .m_valid(m_valid), .cp0_addr(cp0_addr),
    .cp0_we(cp0_we), .cp0_wdata(cp0_wdata), .eret_m(eret_m),
    .cp0_rdata(cp0_rdata), .epc_out(epc_out), .req(req), .handler_pc(handler_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_int();
    return m_sr[0] && !m_sr[1] && ((hwint & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_req();
    return m_int() || (!m_sr[1] && m_valid && exccode_m != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h2021_0706;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [5:0] hw, input logic [31:0] pc, input logic bd,
                       input logic [4:0] ec, input logic mv, input logic [4:0] a,
                       input logic we, input logic [31:0] wd, input logic er);
    hwint = hw; pc_m = pc; bd_m = bd; exccode_m = ec; m_valid = mv;
    cp0_addr = a; cp0_we = we; cp0_wdata = wd; eret_m = er;
  endtask

  // Check combinational outputs, then advance model and DUT by one edge.
  task automatic cyc();
    logic [31:0] n_sr, n_cause, n_epc;
    #1;
    if (!reset) begin
      chk("req", {31'b0, req}, {31'b0, m_req()});
      chk("handler_pc", handler_pc, m_req() ? 32'h0000_4180 : 32'h0);
      chk("epc_out", epc_out, m_epc);
      chk("rdata", cp0_rdata, m_read(cp0_addr));
    end
    n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
    if (reset) begin
      n_sr = 0; n_cause = 0; n_epc = 0;
    end else begin
      n_cause[15:10] = hwint;
      if (m_req()) begin
        n_sr[1] = 1'b1;
        n_cause[31] = bd_m;
        n_cause[6:2] = m_int() ? 5'd0 : exccode_m;
        n_epc = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'd3;
      end else begin
        if (cp0_we && cp0_addr == 5'd12) n_sr = cp0_wdata & 32'h0000_FC03;
        if (eret_m) n_sr[1] = 1'b0;
        if (cp0_we && cp0_addr == 5'd14) n_epc = cp0_wdata & ~32'd3;
      end
    end
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b1;
    drive(6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h2021_0706);
    rd("rst_other", 5'd7, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_hpc", handler_pc, 32'h0);

    // Enable IM[12] and IE, then external interrupt.
    drive(6'd0, 32'h3000, 1'b0, 5'd0, 1'b1, 5'd12, 1'b1, 32'h0000_1C01, 1'b0); cyc();
    drive(6'b000100, 32'h3018, 1'b0, 5'd0, 1'b1, 5'd14, 1'b0, 32'h0, 1'b0);
    #1; chk("irq_req", {31'b0, req}, 32'h1); chk("irq_hpc", handler_pc, 32'h0000_4180);
    cyc();
    drive(6'b000100, 32'h301C, 1'b0, 5'd0, 1'b1, 5'd14, 1'b0, 32'h0, 1'b0);
    rd("irq_epc", 5'd14, 32'h3018);
    rd("irq_cause", 5'd13, 32'h0000_1000);
    rd("irq_sr", 5'd12, 32'h0000_1C03);
    chk("irq_nest", {31'b0, req}, 32'h0);
    chk("eret_tgt", epc_out, 32'h3018);
    cyc();

    // eret with line still high: next cycle interrupts a delay-slot instruction.
    drive(6'b000100, 32'h3100, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 32'h0, 1'b1); cyc();
    drive(6'b000100, 32'h3020, 1'b1, 5'd0, 1'b1, 5'd12, 1'b0, 32'h0, 1'b0);
    #1; chk("reirq_req", {31'b0, req}, 32'h1);
    cyc();
    rd("bd_epc", 5'd14, 32'h301C);
    rd("bd_cause", 5'd13, 32'h8000_1000);

    // Synchronous overflow with SR cleared; eret + mtc0 SR=0 together.
    drive(6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 32'h0, 1'b1); cyc();
    drive(6'd0, 32'h5000, 1'b0, 5'd12, 1'b1, 5'd13, 1'b0, 32'h0, 1'b0);
    #1; chk("ov_req", {31'b0, req}, 32'h1);
    cyc();
    rd("ov_cause", 5'd13, 32'h0000_0030);
    rd("ov_epc", 5'd14, 32'h5000);
    drive(6'd0, 32'h5008, 1'b0, 5'd12, 1'b1, 5'd14, 1'b0, 32'h0, 1'b0);
    #1; chk("ov_exl_req", {31'b0, req}, 32'h0);
    cyc();
    rd("ov_hold", 5'd14, 32'h5000);

    // Interrupt vs RI with a same-cycle mtc0 SR that must be dropped.
    drive(6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 32'h0000_1001, 1'b1); cyc();
    drive(6'b000100, 32'h6000, 1'b0, 5'd10, 1'b1, 5'd12, 1'b1, 32'h0, 1'b0); cyc();
    rd("pri_sr", 5'd12, 32'h0000_1003);
    rd("pri_cause", 5'd13, 32'h0000_1000);

    // mtc0 to Cause is ignored; mtc0 to EPC masks low bits.
    drive(6'b000100, 32'h0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 32'hFFFF_FFFF, 1'b0); cyc();
    rd("cause_ro", 5'd13, 32'h0000_1000);
    drive(6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 32'h1234_5677, 1'b0); cyc();
    rd("epc_wr", 5'd14, 32'h1234_5674);

    // Leave EXL with IE=0, then exception on a delay slot at pc 0: EPC wraps.
    drive(6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 32'h0, 1'b0); cyc();
    drive(6'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd14, 1'b0, 32'h0, 1'b0); cyc();
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);

    // Setting IE with a pending line raises req only on the next cycle.
    drive(6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 32'h0, 1'b0); cyc();
    drive(6'b000100, 32'h7000, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 32'h0000_1001, 1'b0);
    #1; chk("ie_same", {31'b0, req}, 32'h0);
    cyc();
    drive(6'b000100, 32'h7004, 1'b0, 5'd0, 1'b0, 5'd12, 1'b0, 32'h0, 1'b0);
    #1; chk("ie_next", {31'b0, req}, 32'h1);
    cyc();
    rd("bubble_epc", 5'd14, 32'h7004);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      case ($urandom_range(0, 5))
        0: a = 5'd12; 1: a = 5'd13; 2: a = 5'd14; 3: a = 5'd15;
        default: a = 5'($urandom);
      endcase
      reset = ($urandom_range(0, 63) == 0);
      drive(($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
            $urandom, 1'($urandom),
            ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0,
            1'($urandom),
            a,
            $urandom_range(0, 3) == 0,
            ($urandom_range(0, 1) == 0) ? ($urandom | 32'h1) : $urandom,
            $urandom_range(0, 7) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
